// File: rtl/instr_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq_if
//
// Instruction-memory read bus between the fetch sequencer and the instruction
// memory.
//
//   mem_req     master -> slave  one-cycle read request
//   mem_addr    master -> slave  read address, held from req until rvalid
//   mem_rvalid  slave  -> master read data valid
//   mem_rdata   slave  -> master {opcode, operand} word, 2*DATA_WIDTH bits
//
// Modports: master (sequencer side), slave (memory side).
// ---------------------------------------------------------------------------
interface instr_fetch_seq_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    mem_req;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic                    mem_rvalid;
  logic [2*DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );
endinterface : instr_fetch_seq_if

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//
// Instruction fetch/sequencing FSM for the 16-bit processor. Each pass of the
// loop reads the PC off the shared PC bus, fetches one {opcode, operand} word
// from instruction memory, presents it to the execute units until they report
// completion, then strobes the program counter so it advances or branches.
// A word whose opcode[15:8] equals HALT_OP parks the sequencer in HALT until
// reset.
//
// Ports
//   clk             in   clock, all logic on posedge
//   reset           in   synchronous, active-high
//   run             in   level; 1 = sequencer may fetch/execute
//   pc_in           in   PC bus value (valid while pc_read_enable=1)
//   pc_read_enable  out  drives PC onto the bus (ADDR only)
//   pc_enable       out  one-cycle advance/branch strobe to the PC (ADV only)
//   mem             --   instruction memory read bus (master modport)
//   opcode          out  latched opcode, stable from WAIT exit to next rvalid
//   operand         out  latched operand, same stability as opcode
//   instr_valid     out  1 while EXEC presents the instruction
//   exec_done       in   execute units finished
//   halted          out  1 in HALT
//   state_dbg       out  current state encoding
//
// Optional feature (macro IFETCH_SINGLE_STEP_EN)
//   Adds step_mode/step inputs. With step_mode=1, EXEC withholds instr_valid
//   (and ignores exec_done) until a step pulse is sampled inside EXEC.
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [7:0] HALT_OP    = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_read_enable,
  output logic                  pc_enable,
  instr_fetch_seq_if.master     mem,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  instr_valid,
  input  logic                  exec_done,
  output logic                  halted,
`ifdef IFETCH_SINGLE_STEP_EN
  input  logic                  step_mode,
  input  logic                  step,
`endif
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_ADV  = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic                    addr_load;
  logic                    instr_load;
  logic                    mem_req_c;
  logic                    exec_go;
  logic                    is_halt_word;

  // Halt detection looks only at the top byte of the opcode half of the word.
  assign is_halt_word = (mem.mem_rdata[2*DATA_WIDTH-1 -: 8] == HALT_OP);

  // -------------------------------------------------------------------------
  // Single-step gate: exec_go says whether EXEC may present the instruction.
  // -------------------------------------------------------------------------
`ifdef IFETCH_SINGLE_STEP_EN
  logic step_seen;

  // A step pulse only counts while in EXEC; the flag drops when EXEC is left
  // so the next instruction needs its own pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_seen <= 1'b0;
    end else begin
      step_seen <= (state == S_EXEC) && (state_nxt == S_EXEC) && (step_seen || step);
    end
  end

  assign exec_go = !step_mode || step_seen;
`else
  assign exec_go = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state <= state_nxt;
      if (addr_load) begin
        addr_q <= pc_in;
      end
      if (instr_load) begin
        {opcode, operand} <= mem.mem_rdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_read_enable = 1'b0;
    pc_enable      = 1'b0;
    mem_req_c      = 1'b0;
    instr_valid    = 1'b0;
    halted         = 1'b0;
    addr_load      = 1'b0;
    instr_load     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        pc_read_enable = 1'b1;
        mem_req_c      = 1'b1;
        addr_load      = 1'b1;
        state_nxt      = S_WAIT;
      end

      // Wait is unbounded; rvalid outside this state never reaches the latch.
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          instr_load = 1'b1;
          state_nxt  = is_halt_word ? S_HALT : S_EXEC;
        end
      end

      // exec_done is only honoured once the instruction is actually presented.
      S_EXEC: begin
        if (exec_go) begin
          instr_valid = 1'b1;
          if (exec_done) begin
            state_nxt = S_ADV;
          end
        end
      end

      // opcode is still the executed one here, so the PC can decode a jump.
      // run is only consulted at this exit, never mid-instruction.
      S_ADV: begin
        pc_enable = 1'b1;
        state_nxt = run ? S_ADDR : S_IDLE;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The address is passed straight through during the request cycle so the
  // memory sees it together with mem_req, then held from the register.
  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = (state == S_ADDR) ? pc_in : addr_q;
  assign state_dbg    = state;

endmodule : instr_fetch_seq

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//
// Self-checking bench for instr_fetch_seq. The bench plays both the PC bus and
// the instruction memory, and walks each instruction through the fetch loop
// as a transaction: the expected address, latched word, handshake timing and
// PC strobe count all come from the instruction the bench chose to issue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch_seq;

  localparam int DW = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_ADV  = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [DW-1:0] pc_in;
  logic          pc_read_enable;
  logic          pc_enable;
  logic [DW-1:0] opcode;
  logic [DW-1:0] operand;
  logic          instr_valid;
  logic          exec_done;
  logic          halted;
  logic [2:0]    state_dbg;
`ifdef IFETCH_SINGLE_STEP_EN
  logic          step_mode;
  logic          step;
`endif

  int checks    = 0;
  int failures  = 0;
  int pc_en_exp = 0;
  int pc_en_cnt = 0;

  instr_fetch_seq_if #(.DATA_WIDTH(DW)) ifc ();

  instr_fetch_seq #(.DATA_WIDTH(DW), .HALT_OP(8'hFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .pc_in          (pc_in),
    .pc_read_enable (pc_read_enable),
    .pc_enable      (pc_enable),
    .mem            (ifc.master),
    .opcode         (opcode),
    .operand        (operand),
    .instr_valid    (instr_valid),
    .exec_done      (exec_done),
    .halted         (halted),
`ifdef IFETCH_SINGLE_STEP_EN
    .step_mode      (step_mode),
    .step           (step),
`endif
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  // Count every PC strobe the DUT emits, independent of the directed flow.
  always @(posedge clk) begin
    if (pc_enable === 1'b1) pc_en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction, starting in the ADDR cycle. rv_delay>=1 is the
  // WAIT cycle in which rvalid arrives; ed_delay is the number of EXEC cycles
  // before exec_done; run_next is the run level during EXEC/ADV.
  task automatic do_instr(input logic [DW-1:0] pc, input logic [31:0] word,
                          input int rv_delay, input int ed_delay, input logic run_next);
    pc_in = pc;
    #0;
    check("addr_state",   32'(state_dbg),      32'(ST_ADDR));
    check("addr_req",     32'(ifc.mem_req),    32'd1);
    check("addr_pcrd",    32'(pc_read_enable), 32'd1);
    check("addr_mem_addr",32'(ifc.mem_addr),   32'(pc));
    check("addr_no_pcen", 32'(pc_enable),      32'd0);
    tick();
    pc_in = DW'($urandom);
    for (int i = 1; i < rv_delay; i++) begin
      check("wait_state", 32'(state_dbg),   32'(ST_WAIT));
      check("wait_hold",  32'(ifc.mem_addr), 32'(pc));
      check("wait_iv",    32'(instr_valid), 32'd0);
      check("wait_pcen",  32'(pc_enable | ifc.mem_req), 32'd0);
      tick();
    end
    check("wait_hold_last", 32'(ifc.mem_addr), 32'(pc));
    ifc.mem_rvalid = 1'b1;
    ifc.mem_rdata  = word;
    tick();
    ifc.mem_rvalid = 1'b0;
    ifc.mem_rdata  = $urandom;
    if (word[31:24] == 8'hFF) begin
      check("halt_state",  32'(state_dbg), 32'(ST_HALT));
      check("halt_flag",   32'(halted),    32'd1);
      check("halt_opcode", 32'(opcode),    32'(word[31:16]));
      return;
    end
    check("exec_state",   32'(state_dbg),   32'(ST_EXEC));
    check("exec_iv",      32'(instr_valid), 32'd1);
    check("exec_opcode",  32'(opcode),      32'(word[31:16]));
    check("exec_operand", 32'(operand),     32'(word[15:0]));
    run = run_next;
    for (int i = 0; i < ed_delay; i++) begin
      check("exec_iv_hold", 32'(instr_valid), 32'd1);
      check("exec_no_pcen", 32'(pc_enable | ifc.mem_req), 32'd0);
      tick();
    end
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    pc_en_exp++;
    check("adv_state",  32'(state_dbg),   32'(ST_ADV));
    check("adv_pcen",   32'(pc_enable),   32'd1);
    check("adv_no_req", 32'(ifc.mem_req), 32'd0);
    check("adv_opcode", 32'(opcode),      32'(word[31:16]));
    check("adv_iv",     32'(instr_valid), 32'd0);
    tick();
    check("after_adv_state", 32'(state_dbg),   run_next ? 32'(ST_ADDR) : 32'(ST_IDLE));
    check("after_adv_req",   32'(ifc.mem_req), 32'(run_next));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:24] == 8'hFF) w[31:24] = 8'h7F;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    reset          = 1'b1;
    run            = 1'b0;
    pc_in          = '0;
    exec_done      = 1'b0;
    ifc.mem_rvalid = 1'b0;
    ifc.mem_rdata  = '0;
`ifdef IFETCH_SINGLE_STEP_EN
    step_mode      = 1'b0;
    step           = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_state",   32'(state_dbg),      32'(ST_IDLE));
    check("rst_opcode",  32'(opcode),         32'd0);
    check("rst_operand", 32'(operand),        32'd0);
    check("rst_addr",    32'(ifc.mem_addr),   32'd0);
    check("rst_outs",    32'({pc_read_enable, pc_enable, ifc.mem_req, instr_valid, halted}), 32'd0);
    tick();
    check("idle_no_run", 32'(state_dbg), 32'(ST_IDLE));

    run = 1'b1;
    tick();

    // Basic fetch, 4-cycle loop
    do_instr(16'h0000, 32'h0001_1234, 1, 0, 1'b1);
    // Jump: PC presents the branch target on the next ADDR
    do_instr(16'h0001, 32'h7000_0040, 1, 1, 1'b1);
    do_instr(16'h0040, rand_word(), 1, 0, 1'b1);
    // Slow memory
    do_instr(16'h0041, rand_word(), 5, 2, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 12; n++) begin
      do_instr(DW'($urandom), rand_word(), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 3)), 1'b1);
    end

    // run dropped during EXEC: the instruction still finishes, then IDLE
    do_instr(16'h0100, rand_word(), 2, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_stay", 32'(state_dbg),   32'(ST_IDLE));
      check("idle_noreq",32'(ifc.mem_req), 32'd0);
    end
    run = 1'b1;
    tick();

    // Reset in WAIT with a response arriving on the reset edge
    pc_in = 16'h0200;
    tick();
    check("pre_rst_wait", 32'(state_dbg), 32'(ST_WAIT));
    reset          = 1'b1;
    ifc.mem_rvalid = 1'b1;
    ifc.mem_rdata  = 32'hABCD_5678;
    tick();
    reset          = 1'b0;
    ifc.mem_rvalid = 1'b0;
    check("midrst_state",   32'(state_dbg),    32'(ST_IDLE));
    check("midrst_opcode",  32'(opcode),       32'd0);
    check("midrst_operand", 32'(operand),      32'd0);
    check("midrst_addr",    32'(ifc.mem_addr), 32'd0);
    tick();

`ifdef IFETCH_SINGLE_STEP_EN
    // Single-step: EXEC withholds instr_valid until a step inside EXEC
    step_mode = 1'b1;
    w = rand_word();
    pc_in = 16'h0300;
    check("ss_addr", 32'(state_dbg), 32'(ST_ADDR));
    tick();
    step           = 1'b1;
    ifc.mem_rvalid = 1'b1;
    ifc.mem_rdata  = w;
    tick();
    step           = 1'b0;
    ifc.mem_rvalid = 1'b0;
    exec_done      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ss_state", 32'(state_dbg),   32'(ST_EXEC));
      check("ss_no_iv", 32'(instr_valid), 32'd0);
      check("ss_no_pcen", 32'(pc_enable), 32'd0);
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    check("ss_iv", 32'(instr_valid), 32'd1);
    tick();
    exec_done = 1'b0;
    pc_en_exp++;
    check("ss_pcen",   32'(pc_enable), 32'd1);
    check("ss_opcode", 32'(opcode),    32'(w[31:16]));
    tick();
    step_mode = 1'b0;
    do_instr(16'h0301, rand_word(), 1, 0, 1'b1);
`endif

    // Halt word, then 20 cycles of nothing despite run and stray rvalid
    do_instr(16'h0400, 32'hFF00_0000, 2, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ifc.mem_rvalid = 1'($urandom);
      ifc.mem_rdata  = rand_word();
      exec_done      = 1'($urandom);
      tick();
      check("halt_hold_state", 32'(state_dbg), 32'(ST_HALT));
      check("halt_quiet", 32'({pc_enable, ifc.mem_req, pc_read_enable, instr_valid}), 32'd0);
      check("halt_hold_opcode", 32'(opcode), 32'hFF00);
    end
    ifc.mem_rvalid = 1'b0;
    exec_done      = 1'b0;
    check("pcen_count", 32'(pc_en_cnt), 32'(pc_en_exp));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_rst_state",  32'(state_dbg), 32'(ST_IDLE));
    check("halt_rst_halted", 32'(halted),    32'd0);
    check("halt_rst_opcode", 32'(opcode),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_fetch_seq
